// File: rtl/fpu_seq.sv
// Multi-cycle single-precision FPU: FADD, FSUB and shift-add FMUL.
// Denormals flush to zero, rounding truncates, NaNs collapse to 0x7FC00000.
module fpu_seq (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [1:0]  FPUControl,
  input  logic [31:0] SrcA,
  input  logic [31:0] SrcB,
  output logic [31:0] FPUResult,
  output logic [3:0]  FPUFlags,
  output logic        Busy,
  output logic        Done
);

  localparam logic [31:0] QNAN = 32'h7FC0_0000;

  typedef enum logic [2:0] {
    S_IDLE,
    S_UNPACK,
    S_ADD,
    S_MULITER,
    S_NORM,
    S_DONE
  } state_t;

  state_t      state_q, state_d;
  logic [31:0] a_q, a_d;
  logic [31:0] b_q, b_d;
  logic [1:0]  op_q, op_d;
  logic        sign_q, sign_d;
  logic [10:0] exp_q, exp_d;
  logic [47:0] man_q, man_d;
  logic [4:0]  cnt_q, cnt_d;
  logic [31:0] res_q, res_d;
  logic [3:0]  flg_q, flg_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;

  function automatic logic [5:0] lzc48(input logic [47:0] v);
    lzc48 = 6'd48;
    for (int i = 0; i < 48; i++)
      if (v[i]) lzc48 = 6'(47 - i);
  endfunction

  logic [7:0]  ea, eb;
  logic [23:0] ma, mb;
  logic        sa, sb;
  logic        a_zero, b_zero;
  logic        a_inf, b_inf;
  logic        a_nan, b_nan;
  logic        is_mul;

  // sb is the effective sign of B: FSUB folds into FADD here
  assign ea     = a_q[30:23];
  assign eb     = b_q[30:23];
  assign a_zero = (ea == 8'd0);
  assign b_zero = (eb == 8'd0);
  assign a_inf  = (ea == 8'hFF) && (a_q[22:0] == 23'd0);
  assign b_inf  = (eb == 8'hFF) && (b_q[22:0] == 23'd0);
  assign a_nan  = (ea == 8'hFF) && (a_q[22:0] != 23'd0);
  assign b_nan  = (eb == 8'hFF) && (b_q[22:0] != 23'd0);
  assign ma     = a_zero ? 24'd0 : {1'b1, a_q[22:0]};
  assign mb     = b_zero ? 24'd0 : {1'b1, b_q[22:0]};
  assign sa     = a_q[31];
  assign sb     = b_q[31] ^ (op_q == 2'b01);
  assign is_mul = (op_q == 2'b10);

  logic        a_big;
  logic [7:0]  big_e, sml_e, ediff;
  logic [23:0] big_m, sml_m;
  logic [4:0]  sh;
  logic [26:0] big_x, sml_x;
  logic [27:0] sum;

  assign a_big = {ea, ma} >= {eb, mb};
  assign big_e = a_big ? ea : eb;
  assign sml_e = a_big ? eb : ea;
  assign big_m = a_big ? ma : mb;
  assign sml_m = a_big ? mb : ma;
  assign ediff = big_e - sml_e;
  assign sh    = (ediff > 8'd26) ? 5'd26 : ediff[4:0];
  assign big_x = {big_m, 3'b000};
  assign sml_x = {sml_m, 3'b000} >> sh;
  assign sum   = (sa == sb) ? {1'b0, big_x} + {1'b0, sml_x}
                            : {1'b0, big_x} - {1'b0, sml_x};

  logic [47:0] pp;
  assign pp = {24'd0, ma} << cnt_q;

  // man_q holds value * 2^46 relative to exp_q, so 1.0 sits at bit 46
  logic [5:0]  lz;
  logic [22:0] frac;
  logic [10:0] e_fin;
  logic        ovf, unf;

  assign lz    = lzc48(man_q);
  assign frac  = 23'((man_q << lz) >> 24);
  assign e_fin = exp_q + 11'd1 - {5'd0, lz};
  assign ovf   = !e_fin[10] && (e_fin >= 11'd255);
  assign unf   = e_fin[10] || (e_fin == 11'd0);

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    op_d    = op_q;
    sign_d  = sign_q;
    exp_d   = exp_q;
    man_d   = man_q;
    cnt_d   = cnt_q;
    res_d   = res_q;
    flg_d   = flg_q;
    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          a_d     = SrcA;
          b_d     = SrcB;
          op_d    = FPUControl;
          state_d = S_UNPACK;
        end
      end
      S_UNPACK: begin
        state_d = S_DONE;
        if (op_q == 2'b11) begin
          res_d = 32'd0;
          flg_d = 4'b0000;
        end else if (a_nan || b_nan
            || (!is_mul && a_inf && b_inf && (sa != sb))
            || (is_mul && ((a_inf && b_zero) || (a_zero && b_inf)))) begin
          res_d = QNAN;
          flg_d = 4'b0010;
        end else if (is_mul) begin
          if (a_inf || b_inf) begin
            res_d = {sa ^ sb, 8'hFF, 23'd0};
            flg_d = {sa ^ sb, 3'b000};
          end else if (a_zero || b_zero) begin
            res_d = {sa ^ sb, 31'd0};
            flg_d = {sa ^ sb, 3'b100};
          end else begin
            sign_d  = sa ^ sb;
            exp_d   = {3'd0, ea} + {3'd0, eb} - 11'd127;
            man_d   = 48'd0;
            cnt_d   = 5'd0;
            state_d = S_MULITER;
          end
        end else if (a_inf) begin
          res_d = {sa, 8'hFF, 23'd0};
          flg_d = {sa, 3'b000};
        end else if (b_inf) begin
          res_d = {sb, 8'hFF, 23'd0};
          flg_d = {sb, 3'b000};
        end else begin
          state_d = S_ADD;
        end
      end
      S_ADD: begin
        sign_d  = a_big ? sa : sb;
        exp_d   = {3'd0, big_e};
        man_d   = {sum, 20'd0};
        state_d = S_NORM;
      end
      S_MULITER: begin
        if (mb[cnt_q]) man_d = man_q + pp;
        cnt_d = cnt_q + 5'd1;
        if (cnt_q == 5'd23) state_d = S_NORM;
      end
      S_NORM: begin
        state_d = S_DONE;
        if (man_q == 48'd0) begin
          res_d = 32'd0;
          flg_d = 4'b0100;
        end else if (ovf) begin
          res_d = {sign_q, 8'hFF, 23'd0};
          flg_d = {sign_q, 3'b001};
        end else if (unf) begin
          res_d = {sign_q, 31'd0};
          flg_d = {sign_q, 3'b100};
        end else begin
          res_d = {sign_q, e_fin[7:0], frac};
          flg_d = {sign_q, 3'b000};
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    busy_d = (state_d != S_IDLE);
    done_d = (state_d == S_DONE);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      a_q     <= 32'd0;
      b_q     <= 32'd0;
      op_q    <= 2'd0;
      sign_q  <= 1'b0;
      exp_q   <= 11'd0;
      man_q   <= 48'd0;
      cnt_q   <= 5'd0;
      res_q   <= 32'd0;
      flg_q   <= 4'd0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      op_q    <= op_d;
      sign_q  <= sign_d;
      exp_q   <= exp_d;
      man_q   <= man_d;
      cnt_q   <= cnt_d;
      res_q   <= res_d;
      flg_q   <= flg_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign FPUResult = res_q;
  assign FPUFlags  = flg_q;
  assign Busy      = busy_q;
  assign Done      = done_q;

endmodule

// File: tb/tb_fpu_seq.sv
// Directed-vector bench for fpu_seq: results, flags, latency,
// reset abort and start-while-busy behaviour.
module tb_fpu_seq;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [1:0]  FPUControl;
  logic [31:0] SrcA;
  logic [31:0] SrcB;
  logic [31:0] FPUResult;
  logic [3:0]  FPUFlags;
  logic        Busy;
  logic        Done;

  int errors = 0;
  int checks = 0;

  fpu_seq dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .FPUControl (FPUControl),
    .SrcA       (SrcA),
    .SrcB       (SrcB),
    .FPUResult  (FPUResult),
    .FPUFlags   (FPUFlags),
    .Busy       (Busy),
    .Done       (Done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Issue one op, scramble the inputs after acceptance, time Done.
  task automatic run_op(input string tag, input logic [1:0] op,
                        input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] er, input logic [3:0] ef,
                        input int el);
    int   lat;
    logic busy_ok;
    FPUControl = op;
    SrcA       = a;
    SrcB       = b;
    start      = 1'b1;
    @(posedge clk);
    #1;
    start      = 1'b0;
    FPUControl = ~op;
    SrcA       = ~a;
    SrcB       = ~b;
    lat        = 0;
    busy_ok    = 1'b1;
    for (int k = 1; k <= 40 && lat == 0; k++) begin
      @(negedge clk);
      if (Busy !== 1'b1) busy_ok = 1'b0;
      if (Done === 1'b1) lat = k;
    end
    chk({tag, " latency"}, lat, el);
    chk({tag, " result"}, FPUResult, er);
    chk({tag, " flags"}, {28'd0, FPUFlags}, {28'd0, ef});
    chk({tag, " busy"}, {31'd0, busy_ok}, 32'd1);
    @(negedge clk);
    chk({tag, " idle"}, {30'd0, Busy, Done}, 32'd0);
  endtask

  initial begin
    int nd, d1, d2;
    logic busy5;

    reset      = 1'b1;
    start      = 1'b1;
    FPUControl = 2'b00;
    SrcA       = 32'h3F80_0000;
    SrcB       = 32'h4000_0000;
    repeat (3) @(negedge clk);
    chk("reset result", FPUResult, 32'd0);
    chk("reset flags", {28'd0, FPUFlags}, 32'd0);
    chk("reset busy", {31'd0, Busy}, 32'd0);
    chk("reset done", {31'd0, Done}, 32'd0);
    start = 1'b0;
    @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);

    run_op("fadd 1+2", 2'b00, 32'h3F80_0000, 32'h4000_0000,
           32'h4040_0000, 4'b0000, 4);
    run_op("fmul 1.5*-2", 2'b10, 32'h3FC0_0000, 32'hC000_0000,
           32'hC040_0000, 4'b1000, 27);
    run_op("fsub 3-3", 2'b01, 32'h4040_0000, 32'h4040_0000,
           32'h0000_0000, 4'b0100, 4);
    run_op("fadd denorm", 2'b00, 32'h0000_0001, 32'h8000_0000,
           32'h0000_0000, 4'b0100, 4);
    run_op("fmul ovf", 2'b10, 32'h7F00_0000, 32'h4000_0000,
           32'h7F80_0000, 4'b0001, 27);
    run_op("fmul 0*inf", 2'b10, 32'h0000_0000, 32'h7F80_0000,
           32'h7FC0_0000, 4'b0010, 2);
    run_op("reserved", 2'b11, 32'h3F80_0000, 32'h3F80_0000,
           32'h0000_0000, 4'b0000, 2);
    run_op("fadd inf+1", 2'b00, 32'h7F80_0000, 32'h3F80_0000,
           32'h7F80_0000, 4'b0000, 2);
    run_op("fsub 1-inf", 2'b01, 32'h3F80_0000, 32'h7F80_0000,
           32'hFF80_0000, 4'b1000, 2);
    run_op("fsub inf-inf", 2'b01, 32'h7F80_0000, 32'h7F80_0000,
           32'h7FC0_0000, 4'b0010, 2);
    run_op("fmul -0*2", 2'b10, 32'h8000_0000, 32'h4000_0000,
           32'h8000_0000, 4'b1100, 2);
    run_op("fadd 1-0.25", 2'b00, 32'h3F80_0000, 32'hBE80_0000,
           32'h3F40_0000, 4'b0000, 4);
    run_op("fmul 3*3", 2'b10, 32'h4040_0000, 32'h4040_0000,
           32'h4110_0000, 4'b0000, 27);
    run_op("fmul unf", 2'b10, 32'h0080_0000, 32'h3F00_0000,
           32'h0000_0000, 4'b0100, 27);
    run_op("fadd nan", 2'b00, 32'h7FC0_0001, 32'h3F80_0000,
           32'h7FC0_0000, 4'b0010, 2);

    // Abort an FMUL in its tenth cycle
    FPUControl = 2'b10;
    SrcA       = 32'h3FC0_0000;
    SrcB       = 32'hC000_0000;
    start      = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (10) @(negedge clk);
    chk("abort busy before", {31'd0, Busy}, 32'd1);
    reset = 1'b1;
    @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    chk("abort busy", {31'd0, Busy}, 32'd0);
    chk("abort done", {31'd0, Done}, 32'd0);
    chk("abort result", FPUResult, 32'd0);
    chk("abort flags", {28'd0, FPUFlags}, 32'd0);
    nd = 0;
    repeat (40) begin
      @(negedge clk);
      if (Done === 1'b1) nd++;
    end
    chk("abort no done", nd, 0);

    // start held high through a busy FADD
    FPUControl = 2'b00;
    SrcA       = 32'h3F80_0000;
    SrcB       = 32'h4000_0000;
    start      = 1'b1;
    nd = 0;
    d1 = 0;
    d2 = 0;
    busy5 = 1'b1;
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk);
      if (k == 5) busy5 = Busy;
      if (Done === 1'b1) begin
        nd++;
        if (nd == 1) d1 = k;
        if (nd == 2) begin
          d2 = k;
          start = 1'b0;
        end
      end
    end
    start = 1'b0;
    chk("held done count", nd, 2);
    chk("held first done", d1, 4);
    chk("held second done", d2, 9);
    chk("held idle gap", {31'd0, busy5}, 32'd0);
    chk("held result", FPUResult, 32'h4040_0000);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/fpu_seq.md
FPU_SEQ -- requirements
Module: fpu_seq

Interface
REQ-001 The clk input SHALL be 1 bit wide and is the single clock; all state SHALL update on its rising edge.
REQ-002 The reset input SHALL be 1 bit wide, synchronous and active-high.
REQ-003 The start input SHALL be 1 bit wide and request an operation; it is sampled only in IDLE.
REQ-004 The FPUControl input SHALL be 2 bits wide and select the operation: 00 FADD, 01 FSUB, 10 FMUL, 11 reserved.
REQ-005 The SrcA input SHALL be a 32-bit IEEE-754 single-precision operand A.
REQ-006 The SrcB input SHALL be a 32-bit IEEE-754 single-precision operand B.
REQ-007 The FPUResult output SHALL be 32 bits wide, registered, and hold the last completed result.
REQ-008 The FPUFlags output SHALL be 4 bits wide, registered, ordered {N,Z,C,V}, and belong to the last completed result.
REQ-009 The Busy output SHALL be 1 bit wide and be high whenever state is not IDLE; it is used as the stall request to the controller.
REQ-010 The Done output SHALL be 1 bit wide and pulse high for exactly one cycle when FPUResult and FPUFlags become valid.

Function
REQ-011 The FSM SHALL have the states IDLE, UNPACK, ADD, MULITER, NORM and DONE.
REQ-012 In IDLE with start=1, the block SHALL latch SrcA, SrcB and FPUControl and go to UNPACK; start is ignored in every other state.
REQ-013 UNPACK SHALL flush denormal inputs to signed zero, restore the hidden bit and detect special cases; it then goes to ADD (FADD/FSUB), MULITER (FMUL) or DONE (special or reserved).
REQ-014 FSUB SHALL equal FADD with the sign of B inverted.
REQ-015 ADD SHALL, in one cycle, barrel-shift the smaller-exponent mantissa right by the exponent difference (saturated at 26) and add or subtract the magnitudes, then go to NORM.
REQ-016 MULITER SHALL run a shift-add 24x24 mantissa multiply for exactly 24 cycles, with the exponent set to eA+eB-127 and the sign set to sA^sB, then go to NORM.
REQ-017 NORM SHALL normalize in one cycle using a leading-zero count, round by truncation (toward zero) and go to DONE.
REQ-018 A final exponent of 255 or more SHALL give a signed infinity with V=1.
REQ-019 A final exponent of 0 or less SHALL give a signed zero (flush).
REQ-020 An exact zero sum SHALL give +0 (0x00000000).
REQ-021 Any NaN input, inf-inf (effective subtraction) or 0*inf SHALL give 0x7FC00000 with flags 0010.
REQ-022 An inf operand that is not a NaN case SHALL give a correctly signed infinity with V=0.
REQ-023 FMUL with a zero operand SHALL give a zero signed sA^sB.
REQ-024 Reserved op 11 SHALL give result 0x00000000 with flags 0000.
REQ-025 The flags SHALL be set as follows: N=result sign (0 for NaN); Z=1 iff the result is +/-0; C=1 iff the result is NaN; V=1 iff the result overflowed to infinity.
REQ-026 DONE SHALL register FPUResult and FPUFlags, assert Done, and return to IDLE on the next cycle; the outputs then hold until the next DONE.
REQ-027 Latency, counted with start accepted at edge t and Done high in cycle t+n, SHALL be: FADD/FSUB n=4; FMUL n=27; special/reserved n=2.
REQ-028 A new start SHALL be accepted no earlier than the cycle after Done; back-to-back operation therefore costs one IDLE cycle.

Reset
REQ-029 While reset=1, the state SHALL be IDLE and the outputs SHALL be FPUResult=0x00000000, FPUFlags=0000, Busy=0 and Done=0; reset SHALL take priority over start.
REQ-030 Reset asserted mid-operation SHALL abort the operation with no Done pulse and SHALL clear any partial result; the outputs SHALL take their reset values.
REQ-031 The MULITER iteration counter SHALL be cleared by reset and on every entry to MULITER.

Verification
REQ-032 FADD 0x3F800000 + 0x40000000 -> FPUResult 0x40400000, flags 0000, Done exactly 4 cycles after start, Busy high for cycles 1-4.
REQ-033 FMUL 0x3FC00000 * 0xC0000000 -> 0xC0400000, flags 1000, Done 27 cycles after start.
REQ-034 FSUB 0x40400000 - 0x40400000 -> 0x00000000, flags 0100; FADD 0x00000001 + 0x80000000 (denormal flushed) -> 0x00000000, flags 0100.
REQ-035 FMUL 0x7F000000 * 0x40000000 -> 0x7F800000, flags 0001; FMUL 0x00000000 * 0x7F800000 -> 0x7FC00000, flags 0010, Done 2 cycles after start.
REQ-036 Reset during MULITER cycle 10 -> next cycle Busy=0, Done never pulses, FPUResult=0.
REQ-037 start held high during a busy FADD -> the second request is ignored until after Done, and exactly one Done is seen per accepted start.
